// File: rtl/processor.sv
//==============================================================================
// Module   : processor
// Brief    : Multi-cycle 8-bit core with a unified 256x8 program/data RAM,
//            an eight-entry register file, an ALU and a 7-bit flag register.
//            Every instruction is three bytes (opcode, operand1, operand2).
//            It is fetched in three cycles and executed in a fourth.
//            Optional feature macro: PROCESSOR_SHIFT_EN (adds SHL/SHR).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module processor (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       prog_we,
    input  logic [7:0] prog_addr,
    input  logic [7:0] prog_data,
    input  logic [2:0] dbg_reg_sel,
    output logic [7:0] dbg_reg_data,
    output logic [7:0] pc,
    output logic [7:0] opcode,
    output logic [7:0] operand1,
    output logic [7:0] operand2,
    output logic [6:0] flags,
    output logic [2:0] compare_result,
    output logic       halted
);

    // -------------------------------------------------------------------------
    // Opcode map
    // -------------------------------------------------------------------------
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDI = 8'h01;
    localparam logic [7:0] OP_MOV = 8'h02;
    localparam logic [7:0] OP_ADD = 8'h03;
    localparam logic [7:0] OP_SUB = 8'h04;
    localparam logic [7:0] OP_AND = 8'h05;
    localparam logic [7:0] OP_OR  = 8'h06;
    localparam logic [7:0] OP_XOR = 8'h07;
    localparam logic [7:0] OP_NOT = 8'h08;
    localparam logic [7:0] OP_CMP = 8'h09;
    localparam logic [7:0] OP_LD  = 8'h0A;
    localparam logic [7:0] OP_ST  = 8'h0B;
    localparam logic [7:0] OP_JMP = 8'h0C;
    localparam logic [7:0] OP_JZ  = 8'h0D;
`ifdef PROCESSOR_SHIFT_EN
    localparam logic [7:0] OP_SHL = 8'h0E;
    localparam logic [7:0] OP_SHR = 8'h0F;
`endif
    localparam logic [7:0] OP_HLT = 8'hFF;

    // Flag bit positions inside {GT,EQ,LT,V,N,C,Z}
    localparam int FLAG_Z  = 0;
    localparam int FLAG_C  = 1;
    localparam int FLAG_N  = 2;
    localparam int FLAG_V  = 3;
    localparam int FLAG_LT = 4;
    localparam int FLAG_EQ = 5;
    localparam int FLAG_GT = 6;

    // -------------------------------------------------------------------------
    // Sequencer states
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_FETCH_OP = 3'd0,
        ST_FETCH_A  = 3'd1,
        ST_FETCH_B  = 3'd2,
        ST_EXEC     = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Architectural state
    // -------------------------------------------------------------------------
    state_t     state_q;
    logic [7:0] pc_q;
    logic [7:0] opcode_q;
    logic [7:0] operand1_q;
    logic [7:0] operand2_q;
    logic [6:0] flags_q;
    logic       halted_q;
    logic [7:0] regs_q [8];
    logic [7:0] mem_q  [256];

    // -------------------------------------------------------------------------
    // Datapath wires
    // -------------------------------------------------------------------------
    logic [2:0] w_rd_idx;
    logic [2:0] w_rs_idx;
    logic [7:0] w_rd_val;
    logic [7:0] w_rs_val;
    logic [7:0] w_fetch_byte;
    logic [7:0] w_ld_byte;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic       w_st_we;

    // Execute-stage decisions, consumed on the EXEC edge
    logic [7:0] result_d;
    logic       reg_we_d;
    logic       upd_zn_d;
    logic [6:0] flags_d;
    logic       jump_d;
    logic       halt_d;

    // Only the low three operand bits select a register
    assign w_rd_idx = operand1_q[2:0];
    assign w_rs_idx = operand2_q[2:0];
    assign w_rd_val = regs_q[w_rd_idx];
    assign w_rs_val = regs_q[w_rs_idx];

    // Asynchronous RAM reads; a same-cycle write is seen only after the edge
    assign w_fetch_byte = mem_q[pc_q];
    assign w_ld_byte    = mem_q[operand2_q];

    // Nine-bit results expose carry-out and borrow in bit 8
    assign w_sum  = {1'b0, w_rd_val} + {1'b0, w_rs_val};
    assign w_diff = {1'b0, w_rd_val} - {1'b0, w_rs_val};

    // Store is suppressed while rst is high so an aborted EXEC leaves RAM alone
    assign w_st_we = (state_q == ST_EXEC) && (opcode_q == OP_ST) && !rst;

    // Decode the latched opcode into result, writeback, flag and control updates
    always_comb begin
        result_d = w_rd_val;
        reg_we_d = 1'b0;
        upd_zn_d = 1'b0;
        flags_d  = flags_q;
        jump_d   = 1'b0;
        halt_d   = 1'b0;

        case (opcode_q)
            OP_NOP: begin
                reg_we_d = 1'b0;
            end
            OP_LDI: begin
                result_d = operand2_q;
                reg_we_d = 1'b1;
            end
            OP_MOV: begin
                result_d = w_rs_val;
                reg_we_d = 1'b1;
            end
            OP_ADD: begin
                result_d       = w_sum[7:0];
                reg_we_d       = 1'b1;
                upd_zn_d       = 1'b1;
                flags_d[FLAG_C] = w_sum[8];
                flags_d[FLAG_V] = (w_rd_val[7] == w_rs_val[7]) &&
                                  (w_sum[7] != w_rd_val[7]);
            end
            OP_SUB: begin
                result_d       = w_diff[7:0];
                reg_we_d       = 1'b1;
                upd_zn_d       = 1'b1;
                flags_d[FLAG_C] = w_diff[8];
                flags_d[FLAG_V] = (w_rd_val[7] != w_rs_val[7]) &&
                                  (w_diff[7] != w_rd_val[7]);
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                case (opcode_q)
                    OP_AND:  result_d = w_rd_val & w_rs_val;
                    OP_OR:   result_d = w_rd_val | w_rs_val;
                    OP_XOR:  result_d = w_rd_val ^ w_rs_val;
                    default: result_d = ~w_rd_val;
                endcase
                reg_we_d       = 1'b1;
                upd_zn_d       = 1'b1;
                flags_d[FLAG_C] = 1'b0;
                flags_d[FLAG_V] = 1'b0;
            end
            OP_CMP: begin
                // Unsigned three-way compare; N and V are deliberately kept
                flags_d[FLAG_LT] = (w_rd_val <  w_rs_val);
                flags_d[FLAG_EQ] = (w_rd_val == w_rs_val);
                flags_d[FLAG_GT] = (w_rd_val >  w_rs_val);
                flags_d[FLAG_Z]  = (w_rd_val == w_rs_val);
                flags_d[FLAG_C]  = w_diff[8];
            end
            OP_LD: begin
                result_d = w_ld_byte;
                reg_we_d = 1'b1;
            end
            OP_JMP: begin
                jump_d = 1'b1;
            end
            OP_JZ: begin
                jump_d = flags_q[FLAG_Z];
            end
`ifdef PROCESSOR_SHIFT_EN
            OP_SHL: begin
                result_d       = {w_rd_val[6:0], 1'b0};
                reg_we_d       = 1'b1;
                upd_zn_d       = 1'b1;
                flags_d[FLAG_C] = w_rd_val[7];
                flags_d[FLAG_V] = 1'b0;
            end
            OP_SHR: begin
                result_d       = {1'b0, w_rd_val[7:1]};
                reg_we_d       = 1'b1;
                upd_zn_d       = 1'b1;
                flags_d[FLAG_C] = w_rd_val[0];
                flags_d[FLAG_V] = 1'b0;
            end
`endif
            OP_HLT: begin
                halt_d = 1'b1;
            end
            default: begin
                reg_we_d = 1'b0;
            end
        endcase

        // Zero and negative follow the ALU result for arithmetic/logic/shift
        if (upd_zn_d) begin
            flags_d[FLAG_Z] = (result_d == 8'h00);
            flags_d[FLAG_N] = result_d[7];
        end
    end

    // Sequencer: fetch three bytes, execute, repeat until HLT
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= ST_FETCH_OP;
            pc_q       <= 8'h00;
            opcode_q   <= 8'h00;
            operand1_q <= 8'h00;
            operand2_q <= 8'h00;
            flags_q    <= 7'h00;
            halted_q   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            case (state_q)
                ST_FETCH_OP: begin
                    opcode_q <= w_fetch_byte;
                    pc_q     <= pc_q + 8'd1;
                    state_q  <= ST_FETCH_A;
                end
                ST_FETCH_A: begin
                    operand1_q <= w_fetch_byte;
                    pc_q       <= pc_q + 8'd1;
                    state_q    <= ST_FETCH_B;
                end
                ST_FETCH_B: begin
                    operand2_q <= w_fetch_byte;
                    pc_q       <= pc_q + 8'd1;
                    state_q    <= ST_EXEC;
                end
                ST_EXEC: begin
                    flags_q <= flags_d;
                    if (reg_we_d) begin
                        regs_q[w_rd_idx] <= result_d;
                    end
                    // Jump target overrides the pc already advanced by fetch
                    if (jump_d) begin
                        pc_q <= operand2_q;
                    end
                    if (halt_d) begin
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else begin
                        state_q  <= ST_FETCH_OP;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_FETCH_OP;
                end
            endcase
        end
    end

    // RAM writes: store first, load port last so it wins on an address clash
    always_ff @(posedge clk_in) begin
        if (w_st_we) begin
            mem_q[operand2_q] <= w_rd_val;
        end
        if (prog_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    // -------------------------------------------------------------------------
    // Status and debug outputs
    // -------------------------------------------------------------------------
    assign dbg_reg_data   = regs_q[dbg_reg_sel];
    assign pc             = pc_q;
    assign opcode         = opcode_q;
    assign operand1       = operand1_q;
    assign operand2       = operand2_q;
    assign flags          = flags_q;
    assign compare_result = flags_q[6:4];
    assign halted         = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_processor.sv
//==============================================================================
// Module   : tb_processor
// Brief    : Directed self-checking bench for processor. Programs are loaded
//            through the load port, expected architectural results are queued
//            and then compared once the core reports HLT (or at chosen steps).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_processor;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       prog_we = 1'b0;
    logic [7:0] prog_addr = 8'h00;
    logic [7:0] prog_data = 8'h00;
    logic [2:0] dbg_reg_sel = 3'd0;
    wire  [7:0] dbg_reg_data;
    wire  [7:0] pc;
    wire  [7:0] opcode;
    wire  [7:0] operand1;
    wire  [7:0] operand2;
    wire  [6:0] flags;
    wire  [2:0] compare_result;
    wire        halted;

    processor u_dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .prog_data      (prog_data),
        .dbg_reg_sel    (dbg_reg_sel),
        .dbg_reg_data   (dbg_reg_data),
        .pc             (pc),
        .opcode         (opcode),
        .operand1       (operand1),
        .operand2       (operand2),
        .flags          (flags),
        .compare_result (compare_result),
        .halted         (halted)
    );

    always #5 clk_in = ~clk_in;

    // Observation selectors: 0..7 register, else one of the status ports
    localparam int SEL_FLAGS = 8;
    localparam int SEL_PC    = 9;
    localparam int SEL_HALT  = 10;
    localparam int SEL_CMP   = 11;
    localparam int SEL_OPC   = 12;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] exp;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] img[$];
    int         errors = 0;
    int         checks = 0;
    int         cycles;

    task automatic expect_val(input string tag, input int sel, input logic [7:0] e);
        exp_t item;
        item.tag = tag;
        item.sel = sel;
        item.exp = e;
        sb.push_back(item);
    endtask

    task automatic observe(input int sel, output logic [7:0] v);
        if (sel < 8) begin
            @(negedge clk_in);
            dbg_reg_sel = sel[2:0];
            #1;
            v = dbg_reg_data;
        end else begin
            case (sel)
                SEL_FLAGS: v = {1'b0, flags};
                SEL_PC:    v = pc;
                SEL_HALT:  v = {7'd0, halted};
                SEL_CMP:   v = {5'd0, compare_result};
                SEL_OPC:   v = opcode;
                default:   v = 8'hxx;
            endcase
        end
    endtask

    task automatic drain();
        exp_t       e;
        logic [7:0] v;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            observe(e.sel, v);
            checks++;
            assert (v === e.exp) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, v, e.exp);
            end
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, e);
        end
    endtask

    // Load the current image at base through the load port (one byte per cycle)
    task automatic load_img(input logic [7:0] base);
        for (int i = 0; i < img.size(); i++) begin
            @(negedge clk_in);
            prog_we   = 1'b1;
            prog_addr = base + 8'(i);
            prog_data = img[i];
        end
        @(negedge clk_in);
        prog_we = 1'b0;
    endtask

    task automatic hold_reset();
        @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Release reset and count rising edges until halted, bounded by max
    task automatic run_to_halt(input int max, output int n);
        @(negedge clk_in);
        rst = 1'b0;
        n = 0;
        while (!halted && n < max) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        checks++;
        assert (halted === 1'b1) else begin
            errors++;
            $error("FAIL halt_timeout: observed=%b expected=1 after %0d cycles", halted, n);
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        step(3);
        expect_val("rst_pc", SEL_PC, 8'h00);
        expect_val("rst_halted", SEL_HALT, 8'h00);
        expect_val("rst_flags", SEL_FLAGS, 8'h00);
        expect_val("rst_opcode", SEL_OPC, 8'h00);
        expect_val("rst_r3", 3, 8'h00);
        drain();

        // ---------------- T1: basic program, timing, freeze ----------------
        img = '{8'h01,8'h00,8'h02, 8'h01,8'h01,8'h02, 8'h03,8'h00,8'h01, 8'hFF,8'h00,8'h00};
        load_img(8'h00);
        run_to_halt(100, cycles);
        check_int("t1_cycles", cycles, 16);
        expect_val("t1_r0", 0, 8'h04);
        expect_val("t1_r1", 1, 8'h02);
        expect_val("t1_flags", SEL_FLAGS, 8'h00);
        expect_val("t1_pc", SEL_PC, 8'h0C);
        drain();
        step(5);
        expect_val("t1_frozen_pc", SEL_PC, 8'h0C);
        expect_val("t1_frozen_halt", SEL_HALT, 8'h01);
        expect_val("t1_frozen_r0", 0, 8'h04);
        drain();

        // ---------------- T2: ADD overflow to zero, JZ taken ----------------
        hold_reset();
        img = '{8'h01,8'h02,8'h80, 8'h01,8'h03,8'h80, 8'h03,8'h02,8'h03,
                8'h0D,8'h00,8'h18, 8'h01,8'h06,8'h77, 8'hFF,8'h00,8'h00};
        load_img(8'h00);
        img = '{8'hFF,8'h00,8'h00};
        load_img(8'h18);
        run_to_halt(100, cycles);
        expect_val("t2_r2", 2, 8'h00);
        expect_val("t2_r6_skipped", 6, 8'h00);
        expect_val("t2_flags", SEL_FLAGS, 8'h0B);
        expect_val("t2_pc", SEL_PC, 8'h1B);
        drain();

        // ---------------- T3: CMP less-than ----------------
        hold_reset();
        img = '{8'h01,8'h00,8'h05, 8'h01,8'h01,8'h09, 8'h09,8'h00,8'h01, 8'hFF,8'h00,8'h00};
        load_img(8'h00);
        run_to_halt(100, cycles);
        expect_val("t3_cmp", SEL_CMP, 8'h01);
        expect_val("t3_flags", SEL_FLAGS, 8'h12);
        expect_val("t3_r0", 0, 8'h05);
        drain();

        // ---------------- T4: ST/LD, JZ not taken, JMP ----------------
        hold_reset();
        img = '{8'h00};
        load_img(8'h40);
        img = '{8'h01,8'h00,8'h5A, 8'h0B,8'h00,8'h40, 8'h0A,8'h04,8'h40,
                8'h0D,8'h00,8'h30, 8'h0C,8'h00,8'h20, 8'hFF,8'h00,8'h00};
        load_img(8'h00);
        img = '{8'hFF,8'h00,8'h00};
        load_img(8'h20);
        img = '{8'h01,8'h05,8'hEE, 8'hFF,8'h00,8'h00};
        load_img(8'h30);
        @(negedge clk_in);
        rst = 1'b0;
        step(20);
        expect_val("t4_jmp_pc", SEL_PC, 8'h20);
        expect_val("t4_jmp_opc", SEL_OPC, 8'h0C);
        drain();
        run_to_halt(100, cycles);
        check_int("t4_hlt_cycles", cycles, 4);
        expect_val("t4_r4", 4, 8'h5A);
        expect_val("t4_r5", 5, 8'h00);
        expect_val("t4_pc", SEL_PC, 8'h23);
        drain();

        // ---------------- T5: reset during FETCH_B of ADD ----------------
        hold_reset();
        img = '{8'h01,8'h00,8'h03, 8'h01,8'h01,8'h04, 8'h03,8'h00,8'h01, 8'hFF,8'h00,8'h00};
        load_img(8'h00);
        @(negedge clk_in);
        rst = 1'b0;
        step(10);
        @(negedge clk_in);
        rst = 1'b1;
        step(1);
        expect_val("t5_abort_pc", SEL_PC, 8'h00);
        expect_val("t5_abort_opc", SEL_OPC, 8'h00);
        expect_val("t5_abort_halt", SEL_HALT, 8'h00);
        drain();
        run_to_halt(100, cycles);
        check_int("t5_restart_cycles", cycles, 16);
        expect_val("t5_r0", 0, 8'h07);
        expect_val("t5_r1", 1, 8'h04);
        drain();

        // ---------------- T6: logic ops, MOV, unknown opcode, SUB ----------------
        hold_reset();
        img = '{8'h01,8'h00,8'hF0, 8'h01,8'h01,8'h3C, 8'h05,8'h00,8'h01,
                8'h01,8'h02,8'h0F, 8'h06,8'h02,8'h01, 8'h07,8'h01,8'h01,
                8'h08,8'h01,8'h00, 8'h02,8'h03,8'h02, 8'h20,8'h07,8'h11,
                8'h01,8'hFF,8'h99, 8'h04,8'h06,8'h00, 8'hFF,8'h00,8'h00};
        load_img(8'h00);
        run_to_halt(200, cycles);
        expect_val("t6_and", 0, 8'h30);
        expect_val("t6_not", 1, 8'hFF);
        expect_val("t6_or", 2, 8'h3F);
        expect_val("t6_mov", 3, 8'h3F);
        expect_val("t6_sub", 6, 8'hD0);
        expect_val("t6_ldi_hibits", 7, 8'h99);
        expect_val("t6_flags", SEL_FLAGS, 8'h06);
        expect_val("t6_pc", SEL_PC, 8'h24);
        drain();

        // ---------------- T7: shift opcode ----------------
        hold_reset();
        img = '{8'h01,8'h00,8'h81, 8'h01,8'h01,8'h81, 8'h09,8'h00,8'h01,
                8'h0E,8'h00,8'h00, 8'hFF,8'h00,8'h00};
        load_img(8'h00);
        run_to_halt(100, cycles);
`ifdef PROCESSOR_SHIFT_EN
        expect_val("t7_shl_r0", 0, 8'h02);
        expect_val("t7_shl_flags", SEL_FLAGS, 8'h22);
`else
        expect_val("t7_nop_r0", 0, 8'h81);
        expect_val("t7_nop_flags", SEL_FLAGS, 8'h21);
`endif
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: observed=timeout expected=finish");
        $fatal(1, "simulation time bound exceeded");
    end

endmodule

`default_nettype wire
